// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared types and constants for the key load controller
package key_ctrl_pkg;

    localparam int DEF_KEY_WIDTH = 32;
    localparam int DEF_TIMEOUT   = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_ACTIVE,
        ST_FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/key_shift_reg.sv
// rtl/key_shift_reg.sv - shadow key register, bit counter and running parity
module key_shift_reg
    import key_ctrl_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [KEY_WIDTH-1:0] shadow,
    output logic                 key_parity,
    output logic                 parity_bit,
    output logic                 last_bit
);

    localparam int CW = $clog2(KEY_WIDTH + 2);

    logic [CW-1:0] bit_cnt;

    // The transfer after the last key bit carries the parity bit.
    assign last_bit = (bit_cnt == CW'(KEY_WIDTH));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shadow     <= '0;
            bit_cnt    <= '0;
            key_parity <= 1'b0;
            parity_bit <= 1'b0;
        end else if (shift_en) begin
            if (last_bit) begin
                parity_bit <= bit_in;
            end else begin
                for (int i = 0; i < KEY_WIDTH; i++) begin
                    if (bit_cnt == CW'(i)) begin
                        shadow[i] <= bit_in;
                    end
                end
                key_parity <= key_parity ^ bit_in;
            end
            if (bit_cnt != CW'(KEY_WIDTH + 1)) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with parity check and idle timeout
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    output logic                 bit_ready,
    output logic [KEY_WIDTH-1:0] key_bus,
    output logic                 key_valid,
    output logic                 out_en,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t               state;
    logic [TW-1:0]        tcnt;
    logic                 load_req;
    logic                 xfer;
    logic                 last_bit;
    logic                 key_parity;
    logic                 parity_bit;
    logic [KEY_WIDTH-1:0] shadow;

    assign load_req = start && (state == ST_IDLE || state == ST_FAIL || state == ST_ACTIVE);
    assign xfer     = bit_valid && bit_ready;

    key_shift_reg #(
        .KEY_WIDTH(KEY_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_req),
        .shift_en  (xfer),
        .bit_in    (bit_data),
        .shadow    (shadow),
        .key_parity(key_parity),
        .parity_bit(parity_bit),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            bit_ready <= 1'b0;
            key_bus   <= '0;
            key_valid <= 1'b0;
            out_en    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (load_req) begin
            state     <= ST_SHIFT;
            tcnt      <= '0;
            bit_ready <= 1'b1;
            key_bus   <= '0;
            key_valid <= 1'b0;
            out_en    <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (xfer) begin
                        tcnt <= '0;
                        if (last_bit) begin
                            state     <= ST_CHECK;
                            bit_ready <= 1'b0;
                        end
                    end else begin
                        if (tcnt != TO_MAX) begin
                            tcnt <= tcnt + TW'(1);
                        end
                        // This idle cycle brings the counter up to TIMEOUT.
                        if (tcnt >= TO_LAST) begin
                            state     <= ST_FAIL;
                            bit_ready <= 1'b0;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                            err_code  <= ERR_TIMEOUT;
                        end
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (key_parity == parity_bit) begin
                        state     <= ST_ACTIVE;
                        key_bus   <= shadow;
                        key_valid <= 1'b1;
                        out_en    <= 1'b1;
                    end else begin
                        state    <= ST_FAIL;
                        err      <= 1'b1;
                        err_code <= ERR_PARITY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - scoreboard bench for key_load_ctrl
module tb_key_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bit_valid;
    logic        bit_data;
    logic        bit_ready;
    logic [31:0] key_bus;
    logic        key_valid;
    logic        out_en;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    typedef struct {
        logic [31:0] key;
        logic        kv;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_xfer   = 0;

    always #5 clk = ~clk;

    key_load_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bit_valid(bit_valid),
        .bit_data (bit_data),
        .bit_ready(bit_ready),
        .key_bus  (key_bus),
        .key_valid(key_valid),
        .out_en   (out_en),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    task automatic tick();
        if (bit_valid && bit_ready) n_xfer++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        if (gap > 0) begin
            bit_valid = 1'b0;
            repeat (gap) tick();
        end
        bit_valid = 1'b1;
        bit_data  = b;
        tick();
    endtask

    task automatic push_exp(input logic [31:0] key, input logic par);
        exp_t e;
        e.kv   = ((^key) == par);
        e.key  = e.kv ? key : 32'h0;
        e.code = e.kv ? 2'b00 : 2'b01;
        sb.push_back(e);
    endtask

    task automatic stream_key(input logic [31:0] key, input logic par, input int maxgap, input int start_at);
        push_exp(key, par);
        for (int i = 0; i < 33; i++) begin
            if (i == start_at) start = 1'b1;
            send_bit((i < 32) ? key[i] : par, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            start = 1'b0;
        end
        bit_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   t = 0;
        while (!key_valid && !err && t < 10) begin
            tick();
            t++;
        end
        e = sb.pop_front();
        n_checks++;
        if (t >= 10) $display("FAIL %s outcome: no key_valid or err within 10 cycles", name);
        else n_pass++;
        n_checks++;
        if (key_valid !== e.kv) $display("FAIL %s key_valid got=%b exp=%b", name, key_valid, e.kv);
        else n_pass++;
        n_checks++;
        if (out_en !== e.kv) $display("FAIL %s out_en got=%b exp=%b", name, out_en, e.kv);
        else n_pass++;
        n_checks++;
        if (key_bus !== e.key) $display("FAIL %s key_bus got=%h exp=%h", name, key_bus, e.key);
        else n_pass++;
        n_checks++;
        if (err !== !e.kv) $display("FAIL %s err got=%b exp=%b", name, err, !e.kv);
        else n_pass++;
        n_checks++;
        if (err_code !== e.code) $display("FAIL %s err_code got=%b exp=%b", name, err_code, e.code);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy got=%b exp=0", name, busy);
        else n_pass++;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({bit_ready, key_valid, out_en, busy, err} !== 5'b0 || key_bus !== 32'h0 || err_code !== 2'b00)
            $display("FAIL %s outputs got rdy=%b kv=%b oe=%b busy=%b err=%b code=%b key=%h exp all zero",
                     name, bit_ready, key_valid, out_en, busy, err, err_code, key_bus);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_latency();
        logic [31:0] key = 32'hA5A5_0F0F;
        int cyc;
        push_exp(key, 1'b0);
        n_xfer = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        bit_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            bit_data = (i < 32) ? key[i] : 1'b0;
            tick();
            cyc++;
        end
        bit_valid = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || busy !== 1'b1) $display("FAIL latency early cyc=%0d kv=%b busy=%b exp kv=0 busy=1", cyc, key_valid, busy);
        else n_pass++;
        tick();
        cyc++;
        n_checks++;
        if (key_valid !== 1'b1) $display("FAIL latency key_valid at cyc=%0d got=%b exp=1 at cycle 35", cyc, key_valid);
        else n_pass++;
        n_checks++;
        if (n_xfer !== 33) $display("FAIL latency transfers got=%0d exp=33", n_xfer);
        else n_pass++;
        collect("latency");
    endtask

    task automatic test_parity_err();
        do_start();
        stream_key(32'hA5A5_0F0F, 1'b1, 0, -1);
        collect("parity_err");
    endtask

    task automatic test_timeout();
        do_start();
        for (int i = 0; i < 10; i++) send_bit(i[0], 0);
        bit_valid = 1'b0;
        repeat (254) tick();
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL timeout_edge after 254 idle busy=%b err=%b exp busy=1 err=0", busy, err);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || bit_ready !== 1'b0 || key_bus !== 32'h0)
            $display("FAIL timeout after 255 idle err=%b code=%b busy=%b rdy=%b key=%h exp err=1 code=10 busy=0 rdy=0 key=0",
                     err, err_code, busy, bit_ready, key_bus);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'b10) $display("FAIL timeout_sticky err=%b code=%b exp err=1 code=10", err, err_code);
        else n_pass++;
        do_start();
        stream_key(32'h5A5A_1234, ^32'h5A5A_1234, 0, -1);
        collect("timeout_recover");
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 0; i < 21; i++) send_bit(i[1], 0);
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        check_idle("reset_mid");
        tick();
        check_idle("reset_mid_hold");
        do_start();
        stream_key(32'hC3C3_8001, ^32'hC3C3_8001, 0, -1);
        collect("reset_mid_reload");
    endtask

    task automatic test_restart_active();
        do_start();
        stream_key(32'hFFFF_FFFF, 1'b0, 0, -1);
        collect("all_ones");
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || out_en !== 1'b0 || key_bus !== 32'h0 || busy !== 1'b1 || bit_ready !== 1'b1)
            $display("FAIL restart kv=%b oe=%b key=%h busy=%b rdy=%b exp kv=0 oe=0 key=0 busy=1 rdy=1",
                     key_valid, out_en, key_bus, busy, bit_ready);
        else n_pass++;
        stream_key(32'h0F0F_A5A4, ^32'h0F0F_A5A4, 0, 5);
        collect("restart_start_ignored");
    endtask

    task automatic test_random_gaps();
        do_start();
        n_xfer = 0;
        stream_key(32'h1234_5678, 1'b1, 20, -1);
        collect("random_gaps");
        n_checks++;
        if (n_xfer !== 33) $display("FAIL random_gaps transfers got=%0d exp=33", n_xfer);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_parity_err();
        test_timeout();
        test_reset_mid();
        test_restart_active();
        test_random_gaps();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
